sram_read_arbiter: RTL and testbench

- Shares the single read port of the on-chip activation/weight SRAM among NUM_REQ fetch units (e.g. activation fetch, weight fetch, output readback).
- Each requester posts a burst descriptor (base address, beat count). The arbiter grants one burst at a time, drives the SRAM read port, and routes returned data to the granted requester.
- The SRAM write port is not controlled by this block.

---
 rtl/sram_read_arbiter_if.sv | 38 +++
 rtl/sram_read_arbiter.sv | 157 +++++++++++++++
 tb/tb_sram_read_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_read_arbiter_if.sv
// Requester, SRAM read-port and response bundle for sram_read_arbiter.
// slave = arbiter view, master = requester/SRAM side view.
interface sram_read_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = 8
) ();

   logic [NUM_REQ-1:0]            i_req;
   logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr;
   logic [NUM_REQ*LEN_WIDTH-1:0]  i_req_len;
   logic [NUM_REQ-1:0]            o_req_ack;

   logic                          o_sram_read_en;
   logic [ADDR_WIDTH-1:0]         o_sram_read_addr;
   logic [DATA_WIDTH-1:0]         i_sram_data;
   logic                          i_sram_data_valid;

   logic [NUM_REQ-1:0]            o_rsp_valid;
   logic [DATA_WIDTH-1:0]         o_rsp_data;
   logic                          o_rsp_last;
   logic [NUM_REQ-1:0]            o_done;
   logic                          o_busy;

   modport slave (
      input  i_req, i_req_addr, i_req_len, i_sram_data, i_sram_data_valid,
      output o_req_ack, o_sram_read_en, o_sram_read_addr,
      output o_rsp_valid, o_rsp_data, o_rsp_last, o_done, o_busy
   );

   modport master (
      output i_req, i_req_addr, i_req_len, i_sram_data, i_sram_data_valid,
      input  o_req_ack, o_sram_read_en, o_sram_read_addr,
      input  o_rsp_valid, o_rsp_data, o_rsp_last, o_done, o_busy
   );

endinterface

// File: rtl/sram_read_arbiter.sv
// Burst arbiter for the shared SRAM read port: ack + first read 1 cycle after request, 2 idle cycles between bursts, no response backpressure.
// Round-robin by default; defining SRAM_ARB_FIXED_PRIO_EN makes the lowest requesting index always win.
module sram_read_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = 8
) (
   input  logic               i_clk,
   input  logic               i_nrst,
   sram_read_arbiter_if.slave bus
);

   localparam int GW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic [ADDR_WIDTH-1:0] base_q,  base_d;
   logic [LEN_WIDTH-1:0]  len_q,   len_d;
   logic [LEN_WIDTH-1:0]  cnt_q,   cnt_d;

   logic [GW-1:0]         search_base;
   logic [GW:0]           rr_sum;
   logic [GW-1:0]         rr_idx;
   logic [GW-1:0]         sel;
   logic                  sel_vld;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [LEN_WIDTH-1:0]  sel_len;
   logic                  start;
   logic                  active;
   logic [NUM_REQ-1:0]    grant_oh;

`ifdef SRAM_ARB_FIXED_PRIO_EN
   assign search_base = '0;
`else
   logic [GW-1:0]         ptr_q, ptr_d;

   assign search_base = ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (start) begin
         ptr_d = (sel == GW'(NUM_REQ - 1)) ? '0 : sel + GW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // First requester found scanning upward from search_base, wrapping at NUM_REQ.
   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      rr_sum  = '0;
      rr_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rr_sum = {1'b0, search_base} + (GW+1)'(i);
         if (rr_sum >= (GW+1)'(NUM_REQ)) begin
            rr_sum = rr_sum - (GW+1)'(NUM_REQ);
         end
         rr_idx = rr_sum[GW-1:0];
         if (!sel_vld && bus.i_req[rr_idx]) begin
            sel     = rr_idx;
            sel_vld = 1'b1;
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == GW'(i)) begin
            sel_addr = bus.i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_len  = bus.i_req_len[i*LEN_WIDTH +: LEN_WIDTH];
         end
      end
   end

   assign start = (state_q == IDLE) && sel_vld;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // DRAIN lasts exactly one cycle: the final beat lands the cycle after the last read.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sel_vld)        state_d = BURST;
         BURST:   if (cnt_q == len_q) state_d = DRAIN;
         DRAIN:                       state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d = grant_q;
      base_d  = base_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      if (start) begin
         grant_d = sel;
         base_d  = sel_addr;
         len_d   = sel_len;
         cnt_d   = '0;
      end else if (state_q == BURST) begin
         cnt_d   = cnt_q + LEN_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         grant_q <= '0;
         base_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         grant_q <= grant_d;
         base_q  <= base_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
      end
   end

   assign active   = (state_q != IDLE);
   assign grant_oh = active ? (NUM_REQ'(1) << grant_q) : '0;

   // Everything is decoded from registered state so an async reset clears outputs at once.
   always_comb begin
      bus.o_req_ack        = ((state_q == BURST) && (cnt_q == '0)) ? grant_oh : '0;
      bus.o_sram_read_en   = (state_q == BURST);
      bus.o_sram_read_addr = (state_q == BURST) ? base_q + ADDR_WIDTH'(cnt_q) : '0;
      bus.o_rsp_valid      = bus.i_sram_data_valid ? grant_oh : '0;
      bus.o_rsp_data       = active ? bus.i_sram_data : '0;
      bus.o_rsp_last       = (state_q == DRAIN) && bus.i_sram_data_valid;
      bus.o_done           = bus.o_rsp_last ? grant_oh : '0;
      bus.o_busy           = active;
   end

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed bench for sram_read_arbiter; SRAM model returns mem[a] = a one cycle after each read.
module tb_sram_read_arbiter;

   localparam int NR = 4;
   localparam int AW = 8;
   localparam int DW = 64;
   localparam int LW = 8;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   sram_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

   sram_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .i_clk  (clk),
      .i_nrst (nrst),
      .bus    (bus)
   );

   int tests = 0;
   int fails = 0;

   logic          sram_vld = 1'b0;
   logic [DW-1:0] sram_dat = '0;
   logic          inj_vld  = 1'b0;

   always @(posedge clk) begin
      sram_vld <= bus.o_sram_read_en;
      sram_dat <= DW'(bus.o_sram_read_addr);
   end
   assign bus.i_sram_data_valid = sram_vld | inj_vld;
   assign bus.i_sram_data       = sram_dat;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".ack"},     64'(bus.o_req_ack),        64'd0);
      chk({tag, ".read_en"}, 64'(bus.o_sram_read_en),   64'd0);
      chk({tag, ".addr"},    64'(bus.o_sram_read_addr), 64'd0);
      chk({tag, ".rsp_vld"}, 64'(bus.o_rsp_valid),      64'd0);
      chk({tag, ".last"},    64'(bus.o_rsp_last),       64'd0);
      chk({tag, ".done"},    64'(bus.o_done),           64'd0);
      chk({tag, ".busy"},    64'(bus.o_busy),           64'd0);
   endtask

   // Request on port p in the current (idle) cycle and check every cycle through the return to idle.
   task automatic run_burst(input int p, input logic [AW-1:0] base, input logic [LW-1:0] len,
                            input bit scramble);
      logic [AW-1:0] a;
      logic [AW-1:0] prev;
      logic [NR-1:0] oh;
      logic [NR-1:0] ack_exp;
      int            nbeats;
      nbeats = int'(len) + 1;
      oh     = NR'(1) << p;
      bus.i_req_addr[p*AW +: AW] = base;
      bus.i_req_len[p*LW +: LW]  = len;
      bus.i_req[p]               = 1'b1;
      tick();
      bus.i_req[p] = 1'b0;
      for (int k = 0; k < nbeats; k++) begin
         a       = base + AW'(k);
         prev    = a - AW'(1);
         ack_exp = (k == 0) ? oh : '0;
         chk("burst.ack",     64'(bus.o_req_ack),        64'(ack_exp));
         chk("burst.read_en", 64'(bus.o_sram_read_en),   64'd1);
         chk("burst.addr",    64'(bus.o_sram_read_addr), 64'(a));
         chk("burst.busy",    64'(bus.o_busy),           64'd1);
         if (k == 0) begin
            chk("burst.rsp_vld_first", 64'(bus.o_rsp_valid), 64'd0);
         end else begin
            chk("burst.rsp_vld",  64'(bus.o_rsp_valid), 64'(oh));
            chk("burst.rsp_data", bus.o_rsp_data,       64'(prev));
            chk("burst.last_early", 64'(bus.o_rsp_last), 64'd0);
            chk("burst.done_early", 64'(bus.o_done),     64'd0);
         end
         if (scramble && k == 1) bus.i_req_addr[p*AW +: AW] = ~base;
         tick();
      end
      a = base + AW'(len);
      chk("final.read_en", 64'(bus.o_sram_read_en), 64'd0);
      chk("final.ack",     64'(bus.o_req_ack),      64'd0);
      chk("final.rsp_vld", 64'(bus.o_rsp_valid),    64'(oh));
      chk("final.data",    bus.o_rsp_data,          64'(a));
      chk("final.last",    64'(bus.o_rsp_last),     64'd1);
      chk("final.done",    64'(bus.o_done),         64'(oh));
      chk("final.busy",    64'(bus.o_busy),         64'd1);
      tick();
      chk_quiet("after_burst");
   endtask

   initial begin
      int            rr_order [6];
      logic [NR-1:0] oh;

`ifdef SRAM_ARB_FIXED_PRIO_EN
      rr_order = '{0, 0, 0, 0, 0, 0};
`else
      rr_order = '{0, 2, 3, 0, 2, 3};
`endif
      bus.i_req      = '0;
      bus.i_req_addr = '0;
      bus.i_req_len  = '0;

      tick();
      tick();
      chk_quiet("in_reset");
      nrst = 1'b1;
      tick();
      chk_quiet("post_reset");

      // Three requesters held high, single-beat bursts.
      for (int p = 0; p < NR; p++) bus.i_req_addr[p*AW +: AW] = AW'(8'h20 + p);
      bus.i_req = 4'b1101;
      tick();
      for (int i = 0; i < 6; i++) begin
         oh = NR'(1) << rr_order[i];
         chk("rr.ack",  64'(bus.o_req_ack),        64'(oh));
         chk("rr.addr", 64'(bus.o_sram_read_addr), 64'(8'h20 + rr_order[i]));
         if (i == 5) bus.i_req = '0;
         else begin
            tick();
            tick();
            tick();
         end
      end
      tick();
      tick();
      chk_quiet("rr_end");

      run_burst(1, 8'h10, 8'd3,   1'b0);
      run_burst(0, 8'hFE, 8'd3,   1'b0);
      run_burst(2, 8'h40, 8'd0,   1'b0);
      run_burst(1, 8'h80, 8'd255, 1'b0);
      run_burst(3, 8'h30, 8'd5,   1'b1);

      // Data valid with no burst running must not reach any requester.
      inj_vld = 1'b1;
      #1;
      chk("stray.rsp_vld", 64'(bus.o_rsp_valid), 64'd0);
      chk("stray.last",    64'(bus.o_rsp_last),  64'd0);
      tick();
      inj_vld = 1'b0;

      // Reset during beat 2 of an 8-beat burst on port 2.
      bus.i_req_addr[2*AW +: AW] = 8'h50;
      bus.i_req_len[2*LW +: LW]  = 8'd7;
      bus.i_req[2]               = 1'b1;
      tick();
      bus.i_req[2] = 1'b0;
      chk("abort.ack_before", 64'(bus.o_req_ack), 64'(4'b0100));
      tick();
      chk("abort.addr_before", 64'(bus.o_sram_read_addr), 64'h51);
      nrst = 1'b0;
      #1;
      chk_quiet("abort_now");
      tick();
      chk_quiet("abort_hold");
      bus.i_req_addr[0*AW +: AW] = 8'h60;
      bus.i_req_addr[3*AW +: AW] = 8'h70;
      bus.i_req_len[0*LW +: LW]  = 8'd0;
      bus.i_req_len[3*LW +: LW]  = 8'd0;
      bus.i_req                  = 4'b1001;
      tick();
      chk_quiet("abort_hold2");
      nrst = 1'b1;
      tick();
      chk("post_abort.ack0",  64'(bus.o_req_ack),        64'(4'b0001));
      chk("post_abort.addr0", 64'(bus.o_sram_read_addr), 64'h60);
      bus.i_req[0] = 1'b0;
      tick();
      tick();
      tick();
      chk("post_abort.ack3",  64'(bus.o_req_ack),        64'(4'b1000));
      chk("post_abort.addr3", 64'(bus.o_sram_read_addr), 64'h70);
      bus.i_req[3] = 1'b0;
      tick();
      chk("post_abort.done3", 64'(bus.o_done), 64'(4'b1000));
      tick();
      chk_quiet("post_abort_idle");
      tick();
      chk_quiet("post_abort_idle2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
